ble_packet_tx: RTL and testbench
================================

# ble_packet_tx

Bit-serial BLE 1M uncoded packet transmitter: the transmit-side counterpart of the receive chain. It takes a start command with access address, channel and payload length, pulls PDU bytes over a ready/valid byte interface, and emits the packet one bit per symbol period on `symbol_out` with a `symbol_strobe` per bit. The emitted packet is preamble, access address, whitened PDU, then whitened CRC. The block feeds the GFSK modulator/DAC path and doubles as loopback stimulus for the receive chain and packet sniffer.

## Interface
- `CLKS_PER_SYMBOL`, 16, clk cycles per symbol (16 MHz clk → 1 Msym/s)
- `MAX_PAYLOAD`, 37, largest accepted payload length in bytes
- `CRC_POLY`, 24'h00065B, CRC polynomial (Galois form)
- `CRC_INIT`, 24'h555555, CRC preset
- `clk` in 1 system clock, 16 MHz
- `rst` in 1 asynchronous, active-high reset
- `start` in 1 one-cycle request; honoured only in IDLE
- `acc_addr` in 32 access address, sampled on accepted `start`
- `channel` in 6 channel index 0–39 (whitening seed), sampled on accepted `start`
- `payload_len` in 6 payload bytes; values above MAX_PAYLOAD are clamped; sampled on accepted `start`
- `byte_data` in 8 PDU byte: header byte 0, header byte 1, then payload
- `byte_valid` in 1 `byte_data` valid
- `byte_ready` out 1 block can accept a byte
- `symbol_out` out 1 current transmitted bit
- `symbol_strobe` out 1 one-cycle pulse on the first clk of each symbol
- `tx_en` out 1 high for the whole packet
- `done` out 1 one-cycle pulse when the packet ends normally
- `underrun` out 1 one-cycle pulse when the packet is aborted for missing data

## Operation
- Reset: all outputs 0; FSM in IDLE; CRC and whitening state cleared.
- FSM states and exits:
  - IDLE: exits to PREAMBLE on accepted `start`.
  - PREAMBLE: 8 symbols, then ACCESS.
  - ACCESS: 32 symbols, then PDU.
  - PDU: 8·(2+L) symbols, where L = clamped `payload_len`; then CRC.
  - CRC: 24 symbols, then END.
  - END: one cycle, pulses `done`, returns to IDLE.
- Bit order: all fields are sent LSB first, except the CRC.
- Preamble: 8'hAA if `acc_addr[0]`=0, else 8'h55.
- Byte buffer:
  - Single-entry byte buffer; `byte_ready` = buffer empty AND bytes still owed for this packet.
  - A transfer occurs on `byte_valid && byte_ready`.
  - Prefetch begins in PREAMBLE.
  - A byte loaded in the same cycle the buffer is consumed is allowed.
- Underrun: if the buffer is empty when a PDU byte's first symbol is due, the packet aborts:
  - `underrun` pulses, `tx_en` and `symbol_out` drop to 0 that cycle, and the FSM returns to IDLE.
  - No `done` pulse.
- CRC:
  - Preset CRC_INIT at the start of PDU.
  - For each unwhitened PDU bit d: `fb = crc[23]^d`; `crc = {crc[22:0],1'b0} ^ (fb ? CRC_POLY : 0)`.
  - Transmitted crc[23] first, down to crc[0].
- Whitening:
  - 7-bit LFSR w[0..6], seeded at the start of PDU with w[0]=1 and w[1..6]=channel[5..0] (MSB at w[1]).
  - Output bit = w[6]; it is XORed with the PDU and CRC bits.
  - Per bit: w[0]←w[6], w[4]←w[3]^w[6], all other bits shift up by one.
  - Not applied to the preamble or access address.
- `start` while not IDLE is ignored. `start` in the same cycle as END is ignored.
- Reset mid-packet aborts immediately, with no `done` or `underrun` pulse.

## Timing
- Symbol counter runs 0..CLKS_PER_SYMBOL−1. `symbol_out` changes only when the counter is 0, which coincides with `symbol_strobe`.
- Accepted `start` at cycle T: at T+1, `tx_en`=1, `symbol_strobe`=1 and `symbol_out` = first preamble bit.
- Total symbols = 80 + 8L. The last CRC bit is held a full period. END (`done`=1, `tx_en`=0) falls at T+1+(80+8L)·CLKS_PER_SYMBOL.
- A PDU byte must be present in the buffer by the cycle its first bit is strobed.

## Structure
- Package `ble_pkg` holds:
  - CRC_POLY, CRC_INIT, PREAMBLE_0=8'hAA, PREAMBLE_1=8'h55
  - the FSM state enum
  - a whitening-seed function of `channel`
- Sub-module `ble_crc_whiten`: bit-serial CRC plus whitener with `init` (seed), `step`, `din`, `crc_mode` (shift out CRC instead of updating it) and `dout`, so the same block is reusable on the receive side.

## Test plan
- AA=32'h8E89BED6, ch 37, L=6, bytes streamed with no stalls:
  - first 16 symbols 0,1,0,1,0,1,0,1, 0,1,1,0,1,0,1,1
  - 128 symbols total; `done` at T+1+2048
  - CRC matches the reference model
- AA=32'h6B7D9171, ch 37, L=0: preamble 1,0,1,0,1,0,1,0; 80 symbols; first whitening output bit = 1. Loop the output into the receive chain; the packet sniffer asserts `packet_detected`.
- `byte_valid` withheld before byte 3: `underrun` pulses at that byte's first symbol; `tx_en` 0 the same cycle; no `done`.
- `start` pulsed during ACCESS and again in the END cycle: both ignored. A fresh `start` after END is accepted and yields an identical waveform.
- `payload_len`=63: clamped to 37; exactly 39 bytes requested via `byte_ready`.
- `rst` asserted mid-PDU: all outputs 0 asynchronously; the next `start` produces a clean preamble.

Source files
------------

// File: rtl/ble_pkg.sv
// Shared constants, FSM states and whitening seed helper
// for the BLE 1M uncoded packet transmitter.
package ble_pkg;

  localparam logic [23:0] CRC_POLY   = 24'h00065B;
  localparam logic [23:0] CRC_INIT   = 24'h555555;
  localparam logic [7:0]  PREAMBLE_0 = 8'hAA;
  localparam logic [7:0]  PREAMBLE_1 = 8'h55;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_ACCESS,
    ST_PDU,
    ST_CRC,
    ST_END
  } tx_state_e;

  // w[0]=1, w[1..6]=channel[5..0]; vector index == LFSR position
  function automatic logic [6:0] whiten_seed(input logic [5:0] ch);
    return {ch[0], ch[1], ch[2], ch[3], ch[4], ch[5], 1'b1};
  endfunction

endpackage

// File: rtl/ble_packet_tx_if.sv
// Command, byte-stream and symbol signals of the BLE packet
// transmitter; master drives commands/bytes, slave is the block.
interface ble_packet_tx_if;

  logic        start;
  logic [31:0] acc_addr;
  logic [5:0]  channel;
  logic [5:0]  payload_len;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        symbol_out;
  logic        symbol_strobe;
  logic        tx_en;
  logic        done;
  logic        underrun;

  modport master (
    output start, acc_addr, channel, payload_len,
    output byte_data, byte_valid,
    input  byte_ready,
    input  symbol_out, symbol_strobe,
    input  tx_en, done, underrun
  );

  modport slave (
    input  start, acc_addr, channel, payload_len,
    input  byte_data, byte_valid,
    output byte_ready,
    output symbol_out, symbol_strobe,
    output tx_en, done, underrun
  );

endinterface

// File: rtl/ble_crc_whiten.sv
// Bit-serial BLE CRC-24 and data whitener; in crc_mode the CRC
// register is shifted out (MSB first) instead of being updated.
module ble_crc_whiten
  import ble_pkg::*;
#(
  parameter logic [23:0] P_POLY = CRC_POLY,
  parameter logic [23:0] P_INIT = CRC_INIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_init,
  input  logic [6:0] i_seed,
  input  logic       i_step,
  input  logic       i_din,
  input  logic       i_crc_mode,
  output logic       o_dout
);

  logic [23:0] r_crc;
  logic [6:0]  r_w;
  logic        w_fb;
  logic [23:0] w_shl;

  assign w_fb   = r_crc[23] ^ i_din;
  assign w_shl  = {r_crc[22:0], 1'b0};
  assign o_dout = r_w[6] ^ (i_crc_mode ? r_crc[23] : i_din);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_crc <= '0;
      r_w   <= '0;
    end else if (i_init) begin
      r_crc <= P_INIT;
      r_w   <= i_seed;
    end else if (i_step) begin
      r_w <= {r_w[5], r_w[4], r_w[3] ^ r_w[6],
              r_w[2], r_w[1], r_w[0], r_w[6]};
      if (i_crc_mode)
        r_crc <= w_shl;
      else
        r_crc <= w_shl ^ (w_fb ? P_POLY : 24'h0);
    end
  end

endmodule

// File: rtl/ble_packet_tx.sv
// BLE 1M uncoded packet transmitter: preamble, access address,
// whitened PDU and whitened CRC, one bit per symbol period.
module ble_packet_tx
  import ble_pkg::*;
#(
  parameter int CLKS_PER_SYMBOL = 16,
  parameter int MAX_PAYLOAD     = 37
) (
  input logic           clk,
  input logic           rst,
  ble_packet_tx_if.slave bus
);

  localparam int CW = $clog2(CLKS_PER_SYMBOL);

  tx_state_e   r_state;
  logic [CW-1:0] r_cnt;
  logic [4:0]  r_bit;
  logic [31:0] r_aa;
  logic [7:0]  r_pre;
  logic [7:0]  r_buf;
  logic [7:0]  r_shift;
  logic        r_full;
  logic [5:0]  r_owed;
  logic [5:0]  r_pdu_left;
  logic        r_symbol;
  logic        r_strobe;
  logic        r_tx_en;
  logic        r_done;
  logic        r_underrun;

  logic [5:0]  w_len;
  logic [5:0]  w_nbytes;
  logic [7:0]  w_pre;
  logic        w_active;
  logic        w_xfer;
  logic        w_have;
  logic [7:0]  w_byte;
  logic        w_last;
  logic [4:0]  w_bit_nxt;
  logic        w_pdu_end;
  logic        w_byte_due;
  logic        w_consume;
  logic        w_abort;
  logic        w_din;
  logic        w_crc_mode;
  logic        w_step;
  logic        w_init;
  logic        w_dout;
  logic        w_sym;

  assign w_len = (bus.payload_len > 6'(MAX_PAYLOAD)) ?
                 6'(MAX_PAYLOAD) : bus.payload_len;
  assign w_nbytes = w_len + 6'd2;
  assign w_pre = bus.acc_addr[0] ? PREAMBLE_1 : PREAMBLE_0;

  assign w_active = (r_state == ST_PREAMBLE) ||
                    (r_state == ST_ACCESS) ||
                    (r_state == ST_PDU);
  assign bus.byte_ready = w_active && !r_full &&
                          (r_owed != 6'd0);
  assign w_xfer = bus.byte_valid && bus.byte_ready;

  // a byte arriving on the very edge it is needed bypasses the buffer
  assign w_have = r_full || w_xfer;
  assign w_byte = r_full ? r_buf : bus.byte_data;

  assign w_last    = (r_cnt == CW'(CLKS_PER_SYMBOL - 1));
  assign w_bit_nxt = r_bit + 5'd1;
  assign w_pdu_end = (r_state == ST_PDU) && (r_bit == 5'd7) &&
                     (r_pdu_left == 6'd0);
  assign w_byte_due =
    ((r_state == ST_ACCESS) && (r_bit == 5'd31)) ||
    ((r_state == ST_PDU) && (r_bit == 5'd7) &&
     (r_pdu_left != 6'd0));
  assign w_consume = w_last && w_byte_due && w_have;
  assign w_abort   = w_last && w_byte_due && !w_have;

  assign w_din = w_byte_due ? w_byte[0] :
                 r_shift[w_bit_nxt[2:0]];
  assign w_crc_mode = (r_state == ST_CRC) || w_pdu_end;
  assign w_step = w_last && !w_abort &&
    ((r_state == ST_PDU) ||
     ((r_state == ST_ACCESS) && (r_bit == 5'd31)) ||
     ((r_state == ST_CRC) && (r_bit != 5'd23)));
  assign w_init = (r_state == ST_IDLE) && bus.start;

  ble_crc_whiten #(
    .P_POLY (CRC_POLY),
    .P_INIT (CRC_INIT)
  ) u_crc_whiten (
    .clk        (clk),
    .rst        (rst),
    .i_init     (w_init),
    .i_seed     (whiten_seed(bus.channel)),
    .i_step     (w_step),
    .i_din      (w_din),
    .i_crc_mode (w_crc_mode),
    .o_dout     (w_dout)
  );

  always_comb begin
    w_sym = 1'b0;
    unique case (r_state)
      ST_PREAMBLE:
        w_sym = (r_bit == 5'd7) ? r_aa[0] :
                r_pre[w_bit_nxt[2:0]];
      ST_ACCESS:
        w_sym = (r_bit == 5'd31) ? w_dout : r_aa[w_bit_nxt];
      ST_PDU, ST_CRC:
        w_sym = w_dout;
      default:
        w_sym = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_aa       <= '0;
      r_pre      <= '0;
      r_buf      <= '0;
      r_shift    <= '0;
      r_full     <= 1'b0;
      r_owed     <= '0;
      r_pdu_left <= '0;
      r_symbol   <= 1'b0;
      r_strobe   <= 1'b0;
      r_tx_en    <= 1'b0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_strobe   <= 1'b0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
      if (w_xfer)
        r_owed <= r_owed - 6'd1;
      if (w_consume) begin
        r_shift    <= w_byte;
        r_full     <= 1'b0;
        r_pdu_left <= r_pdu_left - 6'd1;
      end else if (w_xfer) begin
        r_buf  <= bus.byte_data;
        r_full <= 1'b1;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state    <= ST_PREAMBLE;
            r_aa       <= bus.acc_addr;
            r_pre      <= w_pre;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_strobe   <= 1'b1;
            r_symbol   <= w_pre[0];
            r_tx_en    <= 1'b1;
            r_owed     <= w_nbytes;
            r_pdu_left <= w_nbytes;
            r_full     <= 1'b0;
          end
        end
        ST_END: r_state <= ST_IDLE;
        default: begin
          r_cnt <= w_last ? '0 : r_cnt + 1'b1;
          if (w_abort) begin
            r_state    <= ST_IDLE;
            r_tx_en    <= 1'b0;
            r_symbol   <= 1'b0;
            r_underrun <= 1'b1;
          end else if (w_last) begin
            r_strobe <= 1'b1;
            r_symbol <= w_sym;
            r_bit    <= w_bit_nxt;
            unique case (r_state)
              ST_PREAMBLE:
                if (r_bit == 5'd7) begin
                  r_state <= ST_ACCESS;
                  r_bit   <= '0;
                end
              ST_ACCESS:
                if (r_bit == 5'd31) begin
                  r_state <= ST_PDU;
                  r_bit   <= '0;
                end
              ST_PDU:
                if (r_bit == 5'd7) begin
                  r_bit <= '0;
                  if (r_pdu_left == 6'd0)
                    r_state <= ST_CRC;
                end
              ST_CRC:
                if (r_bit == 5'd23) begin
                  r_state  <= ST_END;
                  r_strobe <= 1'b0;
                  r_symbol <= 1'b0;
                  r_tx_en  <= 1'b0;
                  r_done   <= 1'b1;
                end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign bus.symbol_out    = r_symbol;
  assign bus.symbol_strobe = r_strobe;
  assign bus.tx_en         = r_tx_en;
  assign bus.done          = r_done;
  assign bus.underrun      = r_underrun;

endmodule

// File: tb/tb_ble_packet_tx.sv
// Directed + randomized bench for ble_packet_tx against a
// bit-stream reference model of the BLE packet format.
module tb_ble_packet_tx;

  localparam int CPS = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ble_packet_tx_if bif();

  ble_packet_tx #(
    .CLKS_PER_SYMBOL (CPS),
    .MAX_PAYLOAD     (37)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  bit         exp_q[$];
  bit         got_q[$];
  bit         ref_q[$];
  logic [7:0] pdu[$];

  int         done_c, und_c, n_done, n_und;
  int         n_xfer, n_glitch, n_tx_after;
  logic       und_tx, und_sym;
  logic [2:0] c1v;
  logic [5:0] rstv;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic fill_pdu(input int n);
    pdu.delete();
    for (int i = 0; i < n; i++)
      pdu.push_back(8'($urandom));
  endtask

  // preamble, AA, then whiten(PDU bits ++ CRC MSB-first)
  task automatic model(input logic [31:0] aa,
                       input logic [5:0] ch,
                       input int L);
    bit db[$];
    logic [23:0] crc;
    bit w[7];
    bit nw[7];
    bit fb;
    exp_q.delete();
    for (int i = 0; i < 8; i++)
      exp_q.push_back(aa[0] ? (i % 2 == 0) : (i % 2 == 1));
    for (int i = 0; i < 32; i++)
      exp_q.push_back(aa[i]);
    for (int b = 0; b < L + 2; b++)
      for (int i = 0; i < 8; i++)
        db.push_back(pdu[b][i]);
    crc = 24'h555555;
    foreach (db[k]) begin
      fb  = crc[23] ^ db[k];
      crc = {crc[22:0], 1'b0} ^ (fb ? 24'h00065B : 24'h0);
    end
    for (int i = 23; i >= 0; i--)
      db.push_back(crc[i]);
    w[0] = 1'b1;
    for (int i = 1; i < 7; i++)
      w[i] = ch[6-i];
    foreach (db[k]) begin
      exp_q.push_back(db[k] ^ w[6]);
      nw[0] = w[6];
      for (int i = 1; i < 7; i++)
        nw[i] = w[i-1];
      nw[4] = w[3] ^ w[6];
      w = nw;
    end
  endtask

  function automatic int nmis(input int lo, input int hi);
    int m = 0;
    for (int i = lo; i < hi; i++)
      if (i >= got_q.size() || i >= exp_q.size() ||
          got_q[i] !== exp_q[i])
        m++;
    return m;
  endfunction

  function automatic logic [15:0] got16();
    logic [15:0] v = '0;
    for (int i = 0; i < 16 && i < got_q.size(); i++)
      v[i] = got_q[i];
    return v;
  endfunction

  task automatic run_pkt(input logic [31:0] aa,
                         input logic [5:0] ch,
                         input logic [5:0] plen,
                         input int hold,
                         input int s1, input int s2,
                         input int rst_at);
    int   idx, nb, budget;
    logic rdy_prev, prev_sym;
    bit   stop;
    got_q.delete();
    done_c = -1; und_c = -1; n_done = 0; n_und = 0;
    n_glitch = 0; n_tx_after = 0;
    und_tx = 1'bx; und_sym = 1'bx;
    c1v = 'x; rstv = 'x;
    nb = pdu.size();
    idx = 0; rdy_prev = 1'b0; prev_sym = 1'b0; stop = 0;
    budget = 1 + CPS * (80 + 8 * 37) + 64;
    @(negedge clk);
    bif.acc_addr    = aa;
    bif.channel     = ch;
    bif.payload_len = plen;
    bif.start       = 1'b1;
    for (int c = 1; c <= budget && !stop; c++) begin
      @(negedge clk);
      bif.start = (c == s1) || (c == s2);
      if (bif.byte_valid && rdy_prev)
        idx++;
      if (c == 1)
        c1v = {bif.tx_en, bif.symbol_strobe, bif.symbol_out};
      if (bif.symbol_strobe)
        got_q.push_back(bif.symbol_out);
      else if (bif.tx_en && bif.symbol_out !== prev_sym)
        n_glitch++;
      prev_sym = bif.symbol_out;
      if (bif.done) begin
        n_done++;
        if (done_c < 0) done_c = c;
      end
      if (done_c > 0 && c > done_c && bif.tx_en)
        n_tx_after++;
      if (bif.underrun) begin
        n_und++;
        und_c   = c;
        und_tx  = bif.tx_en;
        und_sym = bif.symbol_out;
      end
      if (c == rst_at) begin
        rst = 1'b1;
        #1;
        rstv = {bif.tx_en, bif.symbol_out, bif.symbol_strobe,
                bif.done, bif.underrun, bif.byte_ready};
        stop = 1;
      end
      if ((done_c > 0 && c >= done_c + 8) ||
          (und_c > 0 && c >= und_c + 8))
        stop = 1;
      if (idx < nb && idx != hold) begin
        bif.byte_valid = 1'b1;
        bif.byte_data  = pdu[idx];
      end else begin
        bif.byte_valid = 1'b0;
        bif.byte_data  = 8'h00;
      end
      rdy_prev = bif.byte_ready;
    end
    bif.start      = 1'b0;
    bif.byte_valid = 1'b0;
    n_xfer = idx;
    if (rst_at > 0) begin
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] aa;
    logic [5:0]  ch;
    int          L;

    rst = 1'b1;
    bif.start = 1'b0;
    bif.acc_addr = '0;
    bif.channel = '0;
    bif.payload_len = '0;
    bif.byte_data = '0;
    bif.byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs",
        {bif.tx_en, bif.symbol_out, bif.symbol_strobe,
         bif.done, bif.underrun, bif.byte_ready}, 6'h00);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_outs",
        {bif.tx_en, bif.symbol_strobe, bif.byte_ready}, 3'b000);

    // canonical advertising packet, L=6
    aa = 32'h8E89BED6; ch = 6'd37; L = 6;
    fill_pdu(L + 2);
    model(aa, ch, L);
    run_pkt(aa, ch, 6'(L), -1, -1, -1, -1);
    chk("t1_first_cycle", c1v, 3'b110);
    chk("t1_first16", got16(), 16'hD6AA);
    chk("t1_nsym", got_q.size(), 128);
    chk("t1_done_cycle", done_c, 1 + 2048);
    chk("t1_ndone", n_done, 1);
    chk("t1_nund", n_und, 0);
    chk("t1_crc_bits", nmis(104, 128), 0);
    chk("t1_all_bits", nmis(0, 128), 0);
    chk("t1_glitch", n_glitch, 0);

    // empty payload, preamble 0x55
    aa = 32'h6B7D9171; ch = 6'd37; L = 0;
    fill_pdu(2);
    model(aa, ch, L);
    run_pkt(aa, ch, 6'(L), -1, -1, -1, -1);
    chk("t2_preamble", got16() & 16'h00FF, 16'h0055);
    chk("t2_nsym", got_q.size(), 80);
    chk("t2_first_white", got_q[40], pdu[0][0] ^ 1'b1);
    chk("t2_all_bits", nmis(0, 80), 0);
    chk("t2_done_cycle", done_c, 1 + 1280);

    // byte 3 withheld
    aa = $urandom; ch = 6'($urandom_range(0, 39)); L = 10;
    fill_pdu(L + 2);
    model(aa, ch, L);
    run_pkt(aa, ch, 6'(L), 3, -1, -1, -1);
    chk("t3_und_cycle", und_c, 1 + CPS * 64);
    chk("t3_und_txen", und_tx, 1'b0);
    chk("t3_und_sym", und_sym, 1'b0);
    chk("t3_nund", n_und, 1);
    chk("t3_ndone", n_done, 0);
    chk("t3_nxfer", n_xfer, 3);
    chk("t3_nsym", got_q.size(), 64);
    chk("t3_prefix", nmis(0, 64), 0);

    // stray starts in ACCESS and END, then fresh start
    aa = $urandom; ch = 6'($urandom_range(0, 39)); L = 4;
    fill_pdu(L + 2);
    model(aa, ch, L);
    run_pkt(aa, ch, 6'(L), -1, 200, 1 + CPS * 112, -1);
    chk("t4_done_cycle", done_c, 1 + CPS * 112);
    chk("t4_ndone", n_done, 1);
    chk("t4_tx_after", n_tx_after, 0);
    chk("t4_all_bits", nmis(0, 112), 0);
    chk("t4_nsym", got_q.size(), 112);
    ref_q = got_q;
    run_pkt(aa, ch, 6'(L), -1, -1, -1, -1);
    chk("t4_rerun_same", got_q == ref_q, 1'b1);
    chk("t4_rerun_done", done_c, 1 + CPS * 112);

    // oversize length is clamped
    aa = $urandom; ch = 6'($urandom_range(0, 39));
    fill_pdu(65);
    model(aa, ch, 37);
    run_pkt(aa, ch, 6'd63, -1, -1, -1, -1);
    chk("t5_nxfer", n_xfer, 39);
    chk("t5_nsym", got_q.size(), 80 + 8 * 37);
    chk("t5_done_cycle", done_c, 1 + CPS * 376);
    chk("t5_all_bits", nmis(0, 376), 0);

    // reset in the middle of the PDU
    aa = $urandom; ch = 6'($urandom_range(0, 39)); L = 20;
    fill_pdu(L + 2);
    model(aa, ch, L);
    run_pkt(aa, ch, 6'(L), -1, -1, -1, 1 + CPS * 50 + 3);
    chk("t6_rst_outs", rstv, 6'h00);
    chk("t6_rst_ndone", n_done + n_und, 0);
    aa = $urandom; ch = 6'($urandom_range(0, 39)); L = 3;
    fill_pdu(L + 2);
    model(aa, ch, L);
    run_pkt(aa, ch, 6'(L), -1, -1, -1, -1);
    chk("t6_post_preamble", got16() & 16'h00FF,
        aa[0] ? 16'h0055 : 16'h00AA);
    chk("t6_post_bits", nmis(0, 80 + 8 * L), 0);
    chk("t6_post_done", done_c, 1 + CPS * (80 + 8 * L));

    // random packets
    for (int r = 0; r < 3; r++) begin
      aa = $urandom;
      ch = 6'($urandom_range(0, 39));
      L  = $urandom_range(0, 37);
      fill_pdu(L + 2);
      model(aa, ch, L);
      run_pkt(aa, ch, 6'(L), -1, -1, -1, -1);
      chk("rnd_bits", nmis(0, 80 + 8 * L), 0);
      chk("rnd_nsym", got_q.size(), 80 + 8 * L);
      chk("rnd_done", done_c, 1 + CPS * (80 + 8 * L));
      chk("rnd_glitch", n_glitch, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
